// File: rtl/cond_sink_burst.sv
// Conditional burst sink: one control token selects PASS or SINK for a run of 1..2^CW data tokens.
// Latency: a PASS token accepted at edge t is visible on d_o/r_o after edge t when the buffer was empty.
// Backpressure: a_i is registered-only; PASS stalls when the 2-entry buffer is full, SINK never stalls.
module cond_sink_burst #(
  parameter int N  = 32,
  parameter int CW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_i,
  output logic          a_i,
  input  logic [N-1:0]  d_i,
  input  logic          rctl_i,
  input  logic [CW:0]   dctl_i,
  output logic          actl_i,
  output logic          r_o,
  input  logic          a_o,
  output logic [N-1:0]  d_o,
  output logic          busy,
  output logic [DW-1:0] drop_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_mode;       // 1 = PASS, 0 = SINK
  logic [CW:0]     r_rem;        // one bit wider than the length field so 2^CW fits
  logic [N-1:0]    r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic [DW-1:0]   r_drop_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_ctl_xfer;
  logic            w_din_xfer;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_last;
  logic [CW:0]     w_len;

  assign w_full     = (r_count == 2'd2);
  assign w_empty    = (r_count == 2'd0);
  assign w_ctl_xfer = rctl_i & actl_i;
  assign w_din_xfer = r_i & a_i;
  assign w_push     = w_din_xfer & r_mode;
  assign w_drop     = w_din_xfer & ~r_mode;
  assign w_pop      = r_o & a_o;
  assign w_last     = w_din_xfer & (r_rem == (CW+1)'(1));
  assign w_len      = {1'b0, dctl_i[CW-1:0]} + (CW+1)'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: control accept opens a burst, the final data transfer closes it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_ctl_xfer) w_next = S_ACTIVE;
      S_ACTIVE: if (w_last)     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Handshake outputs derive only from registered state, never from a_o or r_i
  always_comb begin
    a_i    = 1'b0;
    actl_i = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: actl_i = 1'b1;
      S_ACTIVE: begin
        busy = 1'b1;
        a_i  = ~r_mode | ~w_full;
      end
      default: actl_i = 1'b0;
    endcase
  end

  // Burst mode and remaining-token count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_rem  <= '0;
    end else if (w_ctl_xfer) begin
      r_mode <= dctl_i[CW];
      r_rem  <= w_len;
    end else if (w_din_xfer) begin
      r_rem  <= r_rem - (CW+1)'(1);
    end
  end

  // Two-entry in-order pass buffer; simultaneous push and pop keeps occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= d_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of sunk tokens
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DW'(1);
  end

  assign r_o      = ~w_empty;
  assign d_o      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cond_sink_burst.sv
// Bench for cond_sink_burst: directed bursts with a scoreboard queue of expected PASS outputs.
// A negedge monitor pops and compares each output transfer; direct checks cover flags and counters.
// A second small instance (DW=2) exercises drop counter saturation.
module tb_cond_sink_burst;

  localparam int N  = 32;
  localparam int CW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_i = 1'b0;
  logic          a_i;
  logic [N-1:0]  d_i = '0;
  logic          rctl_i = 1'b0;
  logic [CW:0]   dctl_i = '0;
  logic          actl_i;
  logic          r_o;
  logic          a_o = 1'b0;
  logic [N-1:0]  d_o;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  // saturation instance
  logic          s_r_i = 1'b0;
  logic          s_a_i;
  logic [7:0]    s_d_i = '0;
  logic          s_rctl_i = 1'b0;
  logic [3:0]    s_dctl_i = '0;
  logic          s_actl_i;
  logic          s_r_o;
  logic          s_a_o = 1'b1;
  logic [7:0]    s_d_o;
  logic          s_busy;
  logic [1:0]    s_drop_cnt;

  int            n_chk  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  logic [N-1:0]  exp_q[$];

  cond_sink_burst #(.N(N), .CW(CW), .DW(DW)) u_dut (
    .clk(clk), .rst(rst),
    .r_i(r_i), .a_i(a_i), .d_i(d_i),
    .rctl_i(rctl_i), .dctl_i(dctl_i), .actl_i(actl_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  cond_sink_burst #(.N(8), .CW(3), .DW(2)) u_sat (
    .clk(clk), .rst(rst),
    .r_i(s_r_i), .a_i(s_a_i), .d_i(s_d_i),
    .rctl_i(s_rctl_i), .dctl_i(s_dctl_i), .actl_i(s_actl_i),
    .r_o(s_r_o), .a_o(s_a_o), .d_o(s_d_o),
    .busy(s_busy), .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next posedge when r_o & a_o
  always @(negedge clk) begin
    if (!rst && r_o && a_o) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected nothing", d_o);
      end else begin
        if (d_o !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", d_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_ctl(input logic pass, input int len);
    int n;
    logic [CW-1:0] l;
    l = CW'(len - 1);
    rctl_i = 1'b1;
    dctl_i = {pass, l};
    n = 0;
    @(negedge clk);
    while (!actl_i && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!actl_i) begin
      n_chk++; n_fail++;
      $display("FAIL ctl_timeout: got actl_i=0 expected 1");
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    rctl_i = 1'b0;
  endtask

  task automatic send_data(input logic [N-1:0] v, input logic pass);
    int n;
    r_i = 1'b1;
    d_i = v;
    n = 0;
    @(negedge clk);
    while (!a_i && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_i) begin
      n_chk++; n_fail++;
      $display("FAIL data_timeout: got a_i=0 expected 1");
    end else if (pass) begin
      exp_q.push_back(v);
    end
    @(posedge clk); #1;
    r_i = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int t0;
    // Reset state
    #2;
    chk("rst_a_i", 64'(a_i), 64'd0);
    chk("rst_actl_i", 64'(actl_i), 64'd1);
    chk("rst_r_o", 64'(r_o), 64'd0);
    chk("rst_d_o", 64'(d_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Data request while idle is ignored
    r_i = 1'b1; d_i = 32'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_a_i", 64'(a_i), 64'd0);
    r_i = 1'b0;

    // 1: PASS len1, latency one edge
    a_o = 1'b0;
    send_ctl(1'b1, 1);
    chk("t1_busy", 64'(busy), 64'd1);
    send_data(32'hA5, 1'b1);
    chk("t1_r_o", 64'(r_o), 64'd1);
    chk("t1_d_o", 64'(d_o), 64'hA5);
    chk("t1_busy_end", 64'(busy), 64'd0);
    a_o = 1'b1;
    drain();
    chk("t1_r_o_empty", 64'(r_o), 64'd0);
    chk("t1_drop", 64'(drop_cnt), 64'd0);

    // 2: SINK len4 then PASS len1
    send_ctl(1'b0, 4);
    for (int k = 0; k < 4; k++) send_data(32'hB0 + k, 1'b0);
    chk("t2_drop", 64'(drop_cnt), 64'd4);
    send_ctl(1'b1, 1);
    send_data(32'h11, 1'b1);
    drain();

    // 3: PASS len16 with output stalled
    a_o = 1'b0;
    send_ctl(1'b1, 16);
    acc = 0;
    r_i = 1'b1; d_i = 32'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_i) begin
        exp_q.push_back(d_i);
        acc++;
        @(posedge clk); #1;
        d_i = 32'h100 + 32'(acc);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("t3_accepted", 64'(acc), 64'd2);
    chk("t3_a_i_stall", 64'(a_i), 64'd0);
    rctl_i = 1'b1; dctl_i = 5'b0_0001;
    @(posedge clk); #1;
    chk("t3_actl_active", 64'(actl_i), 64'd0);
    rctl_i = 1'b0;
    a_o = 1'b1;
    t0 = cyc;
    for (int k = 2; k < 16; k++) send_data(32'h100 + 32'(k), 1'b1);
    chk("t3_cycles", 64'(cyc - t0), 64'd15);
    chk("t3_busy_end", 64'(busy), 64'd0);
    drain();

    // 5: reset mid-burst with two tokens buffered
    send_ctl(1'b1, 8);
    send_data(32'h50, 1'b1);
    repeat (2) @(posedge clk);
    #1 a_o = 1'b0;
    send_data(32'h51, 1'b1);
    send_data(32'h52, 1'b1);
    chk("t5_r_o_pre", 64'(r_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_r_o", 64'(r_o), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_actl", 64'(actl_i), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a_o = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_r_o_after", 64'(r_o), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd0);

    // 6: back-to-back PASS len2 then SINK len2
    send_ctl(1'b1, 2);
    send_data(32'h61, 1'b1);
    send_data(32'h62, 1'b1);
    t0 = cyc;
    send_ctl(1'b0, 2);
    send_data(32'h63, 1'b0);
    chk("t6_bubble", 64'(cyc - t0), 64'd2);
    send_data(32'h64, 1'b0);
    chk("t6_drop", 64'(drop_cnt), 64'd2);
    drain();

    // 4: saturation on the DW=2 instance, SINK len8
    s_rctl_i = 1'b1; s_dctl_i = 4'b0_111;
    @(posedge clk); #1;
    s_rctl_i = 1'b0;
    chk("t4_busy", 64'(s_busy), 64'd1);
    s_r_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_d_i = 8'(k);
      @(posedge clk); #1;
      chk("t4_drop", 64'(s_drop_cnt), (k < 3) ? 64'(k) : 64'd3);
    end
    s_r_i = 1'b0;
    chk("t4_busy_end", 64'(s_busy), 64'd0);
    chk("t4_r_o", 64'(s_r_o), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
